// File: rtl/quiz_pkg.sv
// Shared quiz-responder types: arbiter state encoding, contestant count, clock rate.
// Also a one-hot to index helper used by the arbiter, the top FSM and the display logic.
package quiz_pkg;

  localparam int N_KEY    = 4;
  localparam int KEY_W    = $clog2(N_KEY);
  localparam int S_CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ARMED  = 3'b010,
    ST_LOCKED = 3'b100
  } arb_state_t;

  function automatic logic [KEY_W-1:0] onehot_to_idx(input logic [N_KEY-1:0] oh);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_KEY; i++) begin
      if (oh[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector; rise is valid the cycle after the
// second sync edge. No backpressure: every qualifying edge yields exactly one rise pulse.
module key_sync_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/buzz_arbiter.sv
// Buzz-in arbiter: one winner per armed window (round-robin ties), timeout, false-start lockout.
// Grant appears on the 3rd sampling edge after a press; held until clear (no other backpressure).
module buzz_arbiter
  import quiz_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int RR_EN       = 1,
  parameter int FS_EN       = 1
) (
  input  logic             s_clk,
  input  logic             s_rst,
  input  logic [N_KEY-1:0] key_raw,
  input  logic             arm,
  input  logic             clear,
  output logic             grant_valid,
  output logic [N_KEY-1:0] grant_onehot,
  output logic [KEY_W-1:0] grant_id,
  output logic             no_winner,
  output logic [N_KEY-1:0] blocked,
  output logic             busy
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [KEY_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [N_KEY-1:0] blocked_nxt;
  logic             grant_valid_nxt;
  logic [N_KEY-1:0] grant_onehot_nxt;
  logic [KEY_W-1:0] grant_id_nxt;
  logic             no_winner_nxt;

  logic [N_KEY-1:0] rise;
  logic [N_KEY-1:0] cand;
  logic [KEY_W-1:0] search_base;
  logic [KEY_W-1:0] probe;
  logic [KEY_W-1:0] win_idx;
  logic             win_found;

  key_sync_edge #(.WIDTH(N_KEY)) u_sync (
    .clk  (s_clk),
    .rst  (s_rst),
    .din  (key_raw),
    .rise (rise)
  );

  assign cand        = rise & ~blocked;
  assign search_base = (RR_EN != 0) ? rr_ptr : '0;

  // First candidate at or above search_base, wrapping modulo N_KEY.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int i = 0; i < N_KEY; i++) begin
      probe = search_base + KEY_W'(i);
      if (!win_found && cand[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    timer_nxt        = timer;
    rr_ptr_nxt       = rr_ptr;
    blocked_nxt      = blocked;
    grant_valid_nxt  = grant_valid;
    grant_onehot_nxt = grant_onehot;
    grant_id_nxt     = grant_id;
    no_winner_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (FS_EN != 0) blocked_nxt = blocked | rise;
        if (arm && !clear) begin
          state_nxt = ST_ARMED;
          timer_nxt = '0;
        end
      end
      ST_ARMED: begin
        if (clear) begin
          state_nxt   = ST_IDLE;
          blocked_nxt = '0;
        end else if (win_found) begin
          // A grant beats a coincident timeout.
          state_nxt        = ST_LOCKED;
          grant_valid_nxt  = 1'b1;
          grant_onehot_nxt = {{(N_KEY-1){1'b0}}, 1'b1} << win_idx;
          grant_id_nxt     = onehot_to_idx(grant_onehot_nxt);
          rr_ptr_nxt       = win_idx + KEY_W'(1);
          blocked_nxt      = '0;
        end else if (timer == TIMER_LAST) begin
          state_nxt     = ST_IDLE;
          no_winner_nxt = 1'b1;
          blocked_nxt   = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      ST_LOCKED: begin
        if (clear) begin
          state_nxt        = ST_IDLE;
          grant_valid_nxt  = 1'b0;
          grant_onehot_nxt = '0;
          grant_id_nxt     = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      rr_ptr       <= '0;
      blocked      <= '0;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      grant_id     <= '0;
      no_winner    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      rr_ptr       <= rr_ptr_nxt;
      blocked      <= blocked_nxt;
      grant_valid  <= grant_valid_nxt;
      grant_onehot <= grant_onehot_nxt;
      grant_id     <= grant_id_nxt;
      no_winner    <= no_winner_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_buzz_arbiter.sv
// Self-checking bench for buzz_arbiter: cycle table for grant/false-start, then hand
// sequences for tie-break, timeout, lockout and mid-window reset.
module tb_buzz_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic       arm;
  logic       clear;

  logic       gv, nw, busy;
  logic [3:0] goh, blk;
  logic [1:0] gid;
  logic       f_gv, f_nw, f_busy;
  logic [3:0] f_goh, f_blk;
  logic [1:0] f_gid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  buzz_arbiter #(.TIMEOUT_CYC(20), .RR_EN(1), .FS_EN(1)) dut (
    .s_clk(clk), .s_rst(rst), .key_raw(key_raw), .arm(arm), .clear(clear),
    .grant_valid(gv), .grant_onehot(goh), .grant_id(gid), .no_winner(nw),
    .blocked(blk), .busy(busy)
  );

  buzz_arbiter #(.TIMEOUT_CYC(20), .RR_EN(0), .FS_EN(1)) dut_fp (
    .s_clk(clk), .s_rst(rst), .key_raw(key_raw), .arm(arm), .clear(clear),
    .grant_valid(f_gv), .grant_onehot(f_goh), .grant_id(f_gid), .no_winner(f_nw),
    .blocked(f_blk), .busy(f_busy)
  );

  typedef struct {
    logic       arm;
    logic       clear;
    logic [3:0] key;
    logic       gv;
    logic [3:0] goh;
    logic [1:0] gid;
    logic       busy;
    logic [3:0] blk;
    logic       nw;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [12:0] outs();
    return {gv, goh, gid, busy, blk, nw};
  endfunction

  task automatic add(input logic a, input logic c, input logic [3:0] k, input logic v,
                     input logic [3:0] oh, input logic [1:0] id, input logic b,
                     input logic [3:0] bl, input logic w);
    vec_t r;
    r.arm = a; r.clear = c; r.key = k; r.gv = v; r.goh = oh; r.gid = id;
    r.busy = b; r.blk = bl; r.nw = w;
    vecs.push_back(r);
  endtask

  initial begin
    // Grant of key 2 then clear; false start on key 1 then a later grant of key 2.
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0000, 0);
    add(0, 0, 4'b0100, 0, 4'b0000, 0, 1, 4'b0000, 0);
    add(0, 0, 4'b0100, 0, 4'b0000, 0, 1, 4'b0000, 0);
    add(0, 0, 4'b0100, 1, 4'b0100, 2, 1, 4'b0000, 0);
    add(0, 0, 4'b0000, 1, 4'b0100, 2, 1, 4'b0000, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 0, 4'b0000, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 0, 4'b0010, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0010, 0);
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0010, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0110, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0110, 0, 4'b0000, 0, 1, 4'b0010, 0);
    add(0, 0, 4'b0110, 1, 4'b0100, 2, 1, 4'b0000, 0);
    add(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 0);

    rst = 1'b1; key_raw = '0; arm = 1'b0; clear = 1'b0;
    tick(2);
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;
    tick(1);

    foreach (vecs[i]) begin
      arm = vecs[i].arm; clear = vecs[i].clear; key_raw = vecs[i].key;
      tick(1);
      check($sformatf("table_row_%0d", i), 32'(outs()),
            32'({vecs[i].gv, vecs[i].goh, vecs[i].gid, vecs[i].busy, vecs[i].blk, vecs[i].nw}));
    end
    clear = 1'b0;
    check("rr_after_key2", 32'(dut.rr_ptr), 32'd3);

    // Tie-break: rr_ptr=3, keys 0 and 3 together.
    tick(3);
    arm = 1'b1; tick(1); arm = 1'b0;
    key_raw = 4'b1001; tick(3);
    check("tie1_valid", 32'(gv), 32'd1);
    check("tie1_id_rr", 32'(gid), 32'd3);
    check("tie1_id_fixed", 32'(f_gid), 32'd0);
    key_raw = '0; clear = 1'b1; tick(1); clear = 1'b0;
    tick(3);
    check("tie1_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    arm = 1'b1; tick(1); arm = 1'b0;
    key_raw = 4'b1001; tick(3);
    check("tie2_id_rr", 32'(gid), 32'd0);
    check("tie2_id_fixed", 32'(f_gid), 32'd0);
    check("tie2_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    key_raw = '0; clear = 1'b1; tick(1); clear = 1'b0;
    tick(3);

    // Timeout: no_winner exactly 20 cycles after the arm edge.
    arm = 1'b1; tick(1); arm = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick(1);
      check($sformatf("timeout_nw_c%0d", c), 32'(nw), 32'(c == 20));
      if (c == 19) check("timeout_busy_before", 32'(busy), 32'd1);
      if (c == 20) check("timeout_busy_after", 32'(busy), 32'd0);
    end

    // Press arriving on the timeout cycle wins.
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(17);
    key_raw = 4'b1000; tick(3);
    check("late_grant_valid", 32'(gv), 32'd1);
    check("late_grant_id", 32'(gid), 32'd3);
    check("late_grant_no_nw", 32'(nw), 32'd0);
    tick(1);
    check("late_grant_no_nw_next", 32'(nw), 32'd0);
    check("late_grant_busy", 32'(busy), 32'd1);

    // Lockout while LOCKED, then arm+clear together.
    key_raw = '0; tick(3);
    key_raw = 4'b1011; tick(4);
    check("locked_hold", 32'({gv, goh, gid}), 32'({1'b1, 4'b1000, 2'd3}));
    check("locked_no_block", 32'(blk), 32'd0);
    arm = 1'b1; clear = 1'b1; tick(1); arm = 1'b0; clear = 1'b0;
    check("armclr_outputs", 32'(outs()), 32'd0);
    tick(2);
    check("armclr_not_armed", 32'(busy), 32'd0);
    key_raw = '0; tick(3);
    check("armclr_blocked", 32'(blk), 32'd0);

    // Reset landing on the rise cycle of a press.
    arm = 1'b1; tick(1); arm = 1'b0;
    key_raw = 4'b0001; tick(2);
    rst = 1'b1; key_raw = '0; tick(1);
    check("midrst_outputs", 32'(outs()), 32'd0);
    check("midrst_sync", 32'({dut.u_sync.sync1, dut.u_sync.sync2, dut.u_sync.prev}), 32'd0);
    check("midrst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      check($sformatf("midrst_quiet_c%0d", c), 32'(outs()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/buzz_arbiter.md
Name: buzz_arbiter

Overview:
Contestant buzz-in arbiter for the quiz responder. It sits between the four raw contestant buttons and the top-level quiz FSM.
- The FSM opens an answer window with a pulse on arm.
- The arbiter grants exactly one contestant (round-robin tie-break), or reports a timeout.
- It penalises false starts (presses before the window opens) by blocking that contestant for the next window.
- The grant is held until the FSM acknowledges it with clear.

Parameters:
N_KEY, 4, number of contestants; fixed at 4 for this design.
TIMEOUT_CYC, 500_000_000, answer-window length in s_clk cycles (10 s at 50 MHz); must be at least 2.
RR_EN, 1, 1 = rotating priority on simultaneous presses; 0 = fixed priority, key 0 highest.
FS_EN, 1, 1 = false-start blocking enabled.

Ports:
s_clk  in  1  system clock, 50 MHz
s_rst  in  1  synchronous, active-high reset
key_raw  in  4  asynchronous contestant buttons, active high, already debounced
arm  in  1  1-cycle pulse: open answer window
clear  in  1  1-cycle pulse: release grant / abort window
grant_valid  out  1  high while a winner is held
grant_onehot  out  4  one-hot winner; 0 when grant_valid=0
grant_id  out  2  binary winner index; 0 when grant_valid=0
no_winner  out  1  1-cycle pulse on window timeout
blocked  out  4  contestants locked out of the current/next window
busy  out  1  high in ARMED or LOCKED

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state=IDLE, rr_ptr=0, timer=0, synchronizer flops 0.
- Input path, per key:
  - sync1<=key_raw; sync2<=sync1; prev<=sync2; rise=sync2&~prev.
  - A key sampled high at edge k produces rise during the cycle after edge k+1.
  - Grant outputs update at edge k+2 (3rd sampling edge).
  - A held key produces a single rise; it must be released and pressed again to produce another.
- States: IDLE, ARMED, LOCKED; all outputs registered.
- IDLE:
  - With FS_EN=1, any rise sets the matching blocked bit (sticky).
  - arm -> ARMED, timer loaded with 0.
  - clear is ignored.
- ARMED:
  - cand = rise & ~blocked.
  - If cand!=0, the winner is the first set bit searching upward from rr_ptr (mod 4), or from 0 when RR_EN=0.
  - On a win: grant_onehot/grant_id/grant_valid are set, rr_ptr<=winner+1 mod 4, blocked<=0, state -> LOCKED.
  - Otherwise the timer increments. At timer==TIMEOUT_CYC-1: no_winner pulses for 1 cycle, blocked<=0, state -> IDLE.
  - If a candidate and timeout coincide in the same cycle, the grant wins and no_winner is not asserted.
  - arm is ignored.
- LOCKED:
  - Grant outputs are held stable; all rises are ignored (no blocking).
  - clear -> IDLE with grant outputs cleared at the same edge.
  - arm is ignored.
- clear in ARMED aborts: state -> IDLE, blocked<=0, no_winner not pulsed.
- arm and clear in the same cycle: clear has priority, arm is dropped.
- If all 4 contestants are blocked in ARMED, the window runs to timeout.
- Timer width is $clog2(TIMEOUT_CYC). The timer saturates (it never wraps) because timeout exits the state.
- s_rst asserted in any state returns everything to reset values on the next edge, including blocked and rr_ptr.

Decomposition:
- Shared package quiz_pkg:
  - arbiter state encoding (one-hot, 3 bits)
  - N_KEY=4
  - S_CLK_HZ=50_000_000
  - one_hot-to-index function reused by the top FSM and display logic
- One sub-module: key_sync_edge, a 2-flop synchronizer plus rising-edge detector, parameterised width, instantiated once at width 4.
- Priority search and FSM stay in buzz_arbiter.

Test Plan:
1. Reset, arm, then key_raw=4'b0100 held from edge k -> at edge k+2: grant_valid=1, grant_onehot=4'b0100, grant_id=2, rr_ptr=3, busy=1. Then clear -> next edge: all grant outputs 0, busy=0.
2. Tie-break: rr_ptr=3, keys 0 and 3 rise in the same cycle -> grant_id=3. Re-arm and tie keys 0 and 3 again -> grant_id=0 (rr_ptr=0). With RR_EN=0 -> grant_id=0 both times.
3. False start: in IDLE press key 1 -> blocked=4'b0010. Arm; key 1 rises, then key 2 rises 5 cycles later -> no grant on key 1, grant_id=2, blocked=0 at grant.
4. Timeout (TIMEOUT_CYC=20): arm, no presses -> no_winner high for exactly 1 cycle, 20 cycles after the arm edge; state IDLE. Key press on the timeout cycle -> grant, no no_winner.
5. Lockout: in LOCKED press keys 0/1/3 -> grant outputs unchanged, blocked stays 0. arm+clear in the same cycle -> IDLE, not re-armed.
6. Mid-window reset: arm, press key 0, assert s_rst on the rise cycle -> after the reset edge all outputs 0, no grant appears afterward; sync flops cleared.
